seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   Accepts one operand pair per transaction and computes it over WIDTH clock cycles.
//   Raises res_rdy with the product held on res.
//   Sits as a compute leaf behind a simple valid/ready-style controller.
// PARAMETERS
//   WIDTH  8  operand width in bits; result width is 2*WIDTH
// PORTS
//   clk     in   1        rising-edge clock, the single clock domain
//   rst     in   1        reset, synchronous and active-high
//   in_a    in   WIDTH    multiplicand (unsigned)
//   in_b    in   WIDTH    multiplier (unsigned)
//   in_vld  in   1        operand pair valid; sampled only while res_rdy=1
//   res     out  2*WIDTH  product of the last completed transaction
//   res_rdy out  1        1 = idle, res valid, new operands accepted
// BEHAVIOUR
//   - Reset (rst=1 at a posedge): res=0, res_rdy=1, FSM=IDLE, internal regs cleared.
//     Reset mid-computation aborts the operation, with the same values as above.
//   - FSM states:
//     - IDLE: res_rdy=1.
//       On a posedge with in_vld=1, latch in_a into the multiplicand reg and in_b into the shift reg.
//       Clear the accumulator and the counter, then go to BUSY.
//       With in_vld=0, stay in IDLE.
//     - BUSY: res_rdy=0.
//       Each posedge: if shift_reg[0] is set, acc += mcand << count.
//       Then shift shift_reg right by 1 and increment count.
//       On the WIDTH-th BUSY edge (count==WIDTH-1): res <= final acc, go to IDLE.
//   - Latency: accept edge E0.
//     res_rdy is low after E0 through E(WIDTH-1), then high after E(WIDTH) with res valid.
//     This gives WIDTH cycles of busy and one accept per WIDTH+1 cycles.
//   - Operands are captured at accept.
//     in_a and in_b may change freely afterwards without affecting the result.
//   - in_vld while BUSY is ignored (no queueing, no error).
//     in_vld is don't-care (may be X) while BUSY.
//   - res holds the previous result throughout BUSY.
//     It changes only at completion or reset and never shows partial sums.
//   - Arithmetic: unsigned, exact, 2*WIDTH bits, no overflow possible.
//     The accumulator is 2*WIDTH bits wide.
//   - Zero operands still take the full WIDTH cycles (no early termination).
//   - Back-to-back: in_vld=1 on the first IDLE cycle after completion is accepted.
// TESTING
//   - Reset: hold rst=1 for 1 cycle -> res=0, res_rdy=1 immediately after.
//   - Basic: in_a=13, in_b=11, in_vld pulse -> res_rdy low 8 cycles, then res=143, res_rdy=1.
//   - Max: in_a=255, in_b=255 -> res=65025 (16'hFE01); next 0*200 -> res=0 after 8 cycles.
//   - Busy ignore: accept 7*6, pulse in_vld with 100*100 during BUSY -> res=42,
//     no second transaction.
//   - Reset mid-op: accept 200*3, assert rst at cycle 4 -> res=0, res_rdy=1,
//     no later update.
//   - Random: 200 random pairs, each issued when res_rdy=1 -> res == a*b every time;
//     res stable while busy.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One operand pair per transaction, WIDTH busy cycles, result held on res.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_vld,
    output logic [2*WIDTH-1:0]   res,
    output logic                 res_rdy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   shift_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last;

    assign accept = (state == IDLE) && in_vld;
    assign last   = (state == BUSY) && (count == LAST);

    // Partial product for this step; the final step's sum goes straight to res.
    always_comb begin
        acc_nxt = acc;
        if (shift_reg[0]) begin
            acc_nxt = acc + ({{WIDTH{1'b0}}, mcand} << count);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake output.
    always_comb begin
        state_nxt = state;
        res_rdy   = 1'b0;
        case (state)
            IDLE: begin
                res_rdy = 1'b1;
                if (in_vld) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture at accept, one shift-add per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            shift_reg <= '0;
            acc       <= '0;
            count     <= '0;
            res       <= '0;
        end else if (accept) begin
            mcand     <= in_a;
            shift_reg <= in_b;
            acc       <= '0;
            count     <= '0;
        end else if (state == BUSY) begin
            acc       <= acc_nxt;
            shift_reg <= shift_reg >> 1;
            count     <= count + 1'b1;
            if (last) begin
                res <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed + random bench for seq_multiplier.
// Expected products are queued at accept and popped at completion.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_vld;
    logic [2*W-1:0] res;
    logic           res_rdy;

    int n_cmp;
    int n_err;
    logic [2*W-1:0] sb[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_vld  (in_vld),
        .res     (res),
        .res_rdy (res_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!res_rdy && n < 20) begin
            step();
            n++;
        end
        if (!res_rdy) chk("idle_timeout", 32'(res_rdy), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
        logic [2*W-1:0] prev;
        logic [2*W-1:0] exp;
        int cyc;
        wait_idle();
        prev   = res;
        in_a   = a;
        in_b   = b;
        in_vld = 1'b1;
        sb.push_back((2*W)'(a) * (2*W)'(b));
        step();
        in_vld = 1'b0;
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        chk("rdy_low", 32'(res_rdy), 32'd0);
        cyc = 1;
        while (!res_rdy && cyc < W + 4) begin
            chk("res_hold", 32'(res), 32'(prev));
            if (poke && cyc == 2) begin
                in_vld = 1'b1;
                in_a   = 8'd100;
                in_b   = 8'd100;
            end else begin
                in_vld = 1'b0;
            end
            step();
            cyc++;
        end
        in_vld = 1'b0;
        chk("latency", 32'(cyc), 32'(W + 1));
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("product", 32'(res), 32'(exp));
        end else begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        in_a   = '0;
        in_b   = '0;
        in_vld = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_rdy", 32'(res_rdy), 32'd1);

        do_op(8'd13, 8'd11, 1'b0);
        do_op(8'd255, 8'd255, 1'b0);
        chk("max_hex", 32'(res), 32'h0000_FE01);
        do_op(8'd0, 8'd200, 1'b0);

        do_op(8'd7, 8'd6, 1'b1);
        repeat (3) begin
            step();
            chk("ignore_rdy", 32'(res_rdy), 32'd1);
            chk("ignore_res", 32'(res), 32'd42);
        end

        in_a   = 8'd200;
        in_b   = 8'd3;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (3) step();
        chk("midop_busy", 32'(res_rdy), 32'd0);
        chk("midop_hold", 32'(res), 32'd42);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_res", 32'(res), 32'd0);
        chk("abort_rdy", 32'(res_rdy), 32'd1);
        repeat (W + 2) begin
            step();
            chk("abort_quiet", 32'({res_rdy, res}), 32'({1'b1, 16'd0}));
        end

        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
